// File: rtl/rob_tag_alloc_pkg.sv
// Shared ROB tag definitions: tag width, ring size and the reset/null tag.
package rob_tag_alloc_pkg;

  localparam int ROB_SIZE_W = 4;
  localparam int ROB_SIZE   = 16;

  localparam int TAG_W    = ROB_SIZE_W;
  localparam int NUM_TAGS = ROB_SIZE;

  typedef logic [TAG_W-1:0] rob_tag_t;

  localparam rob_tag_t NULL_TAG = '0;

endpackage

// File: rtl/rob_tag_alloc.sv
// Issue-side ROB tag allocator: in-order tag handout, registered ROB push,
// in-order reclaim on commit, full flush on mispredict, occupancy tracking.
module rob_tag_alloc #(
  parameter int TAG_W    = rob_tag_alloc_pkg::TAG_W,
  parameter int NUM_TAGS = rob_tag_alloc_pkg::NUM_TAGS
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  input  logic               alloc_req,
  input  logic [31:0]        alloc_pc,
  output logic               alloc_grant,
  output logic [TAG_W-1:0]   alloc_tag,
  output logic               push_valid,
  output logic [TAG_W-1:0]   push_tag,
  output logic [31:0]        push_src_addr,
  input  logic               commit_valid,
  input  logic [TAG_W-1:0]   commit_tag,
  input  logic               predict_fail,
  output logic [TAG_W:0]     count,
  output logic               full,
  output logic               empty,
  output logic               err
);

  import rob_tag_alloc_pkg::*;

  localparam logic [TAG_W-1:0] RST_TAG  = TAG_W'(NULL_TAG);
  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(NUM_TAGS);

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             err_q, err_d;
  logic             push_valid_q, push_valid_d;
  logic [TAG_W-1:0] push_tag_q, push_tag_d;
  logic [31:0]      push_src_addr_q, push_src_addr_d;
  logic             commit_legal;

  assign full          = (count_q == FULL_CNT);
  assign empty         = (count_q == '0);
  assign count         = count_q;
  assign err           = err_q;
  assign alloc_tag     = tail_q;
  assign push_valid    = push_valid_q;
  assign push_tag      = push_tag_q;
  assign push_src_addr = push_src_addr_q;

  // Grant looks only at the registered count, so a same-cycle commit
  // cannot free a slot for a full allocator.
  assign alloc_grant  = alloc_req & rdy_in & ~full & ~predict_fail;
  assign commit_legal = commit_valid & ~empty & (commit_tag == head_q);

  always_comb begin
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    err_d           = err_q;
    push_valid_d    = push_valid_q;
    push_tag_d      = push_tag_q;
    push_src_addr_d = push_src_addr_q;

    if (rdy_in) begin
      if (predict_fail) begin
        head_d       = RST_TAG;
        tail_d       = RST_TAG;
        count_d      = '0;
        push_valid_d = 1'b0;
      end else begin
        push_valid_d = alloc_grant;
        if (alloc_grant) begin
          push_tag_d      = tail_q;
          push_src_addr_d = alloc_pc;
          tail_d          = tail_q + TAG_W'(1);
        end
        if (commit_legal) begin
          head_d = head_q + TAG_W'(1);
        end else if (commit_valid) begin
          err_d = 1'b1;
        end
        if (alloc_grant && !commit_legal) begin
          count_d = count_q + (TAG_W+1)'(1);
        end else if (!alloc_grant && commit_legal) begin
          count_d = count_q - (TAG_W+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q          <= RST_TAG;
      tail_q          <= RST_TAG;
      count_q         <= '0;
      err_q           <= 1'b0;
      push_valid_q    <= 1'b0;
      push_tag_q      <= RST_TAG;
      push_src_addr_q <= '0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      err_q           <= err_d;
      push_valid_q    <= push_valid_d;
      push_tag_q      <= push_tag_d;
      push_src_addr_q <= push_src_addr_d;
    end
  end

endmodule

// File: tb/tb_rob_tag_alloc.sv
// Self-checking bench for rob_tag_alloc: directed scenarios with literal
// expectations plus randomized traffic against a queue-based occupancy model.
module tb_rob_tag_alloc;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        alloc_req;
  logic [31:0] alloc_pc;
  logic        alloc_grant;
  logic [3:0]  alloc_tag;
  logic        push_valid;
  logic [3:0]  push_tag;
  logic [31:0] push_src_addr;
  logic        commit_valid;
  logic [3:0]  commit_tag;
  logic        predict_fail;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        err;

  int checkCount = 0;
  int passCount  = 0;

  // Model: the outstanding tags in program order, next tag to hand out,
  // and the last values pushed to the ROB.
  int          mTags[$];
  int          mTail;
  bit          mPushValid;
  int          mPushTag;
  logic [31:0] mPushAddr;
  bit          mErr;

  rob_tag_alloc dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .alloc_req(alloc_req), .alloc_pc(alloc_pc), .alloc_grant(alloc_grant),
    .alloc_tag(alloc_tag), .push_valid(push_valid), .push_tag(push_tag),
    .push_src_addr(push_src_addr), .commit_valid(commit_valid),
    .commit_tag(commit_tag), .predict_fail(predict_fail), .count(count),
    .full(full), .empty(empty), .err(err)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else
      passCount++;
  endtask

  task automatic modelReset();
    mTags.delete();
    mTail      = 0;
    mPushValid = 0;
    mPushTag   = 0;
    mPushAddr  = 32'h0;
    mErr       = 0;
  endtask

  // Drive one cycle's inputs shortly after the falling edge.
  task automatic applyStimulus(input bit req, input logic [31:0] pc, input bit cv,
                               input int ctag, input bit pf, input bit rdy);
    alloc_req    = req;
    alloc_pc     = pc;
    commit_valid = cv;
    commit_tag   = 4'(ctag);
    predict_fail = pf;
    rdy_in       = rdy;
    #1;
  endtask

  // Compare every output against the model, advance the model across the
  // coming rising edge, then wait for the next falling edge.
  task automatic checkOutput();
    bit expGrant;
    bit legal;
    int n;
    n        = mTags.size();
    expGrant = alloc_req && rdy_in && (n < 16) && !predict_fail;
    checkVal("alloc_grant",   64'(alloc_grant),   64'(expGrant));
    checkVal("alloc_tag",     64'(alloc_tag),     64'(mTail));
    checkVal("count",         64'(count),         64'(n));
    checkVal("full",          64'(full),          64'(n == 16));
    checkVal("empty",         64'(empty),         64'(n == 0));
    checkVal("push_valid",    64'(push_valid),    64'(mPushValid));
    checkVal("push_tag",      64'(push_tag),      64'(mPushTag));
    checkVal("push_src_addr", 64'(push_src_addr), 64'(mPushAddr));
    checkVal("err",           64'(err),           64'(mErr));

    if (rdy_in) begin
      if (predict_fail) begin
        mTags.delete();
        mTail      = 0;
        mPushValid = 0;
      end else begin
        legal = commit_valid && (n != 0) && (int'(commit_tag) == mTags[0]);
        if (commit_valid && !legal) mErr = 1;
        mPushValid = expGrant;
        if (expGrant) begin
          mPushTag  = mTail;
          mPushAddr = alloc_pc;
          mTags.push_back(mTail);
          mTail = (mTail + 1) % 16;
        end
        if (legal) void'(mTags.pop_front());
      end
    end
    @(negedge clk_in);
  endtask

  task automatic applyReset();
    @(negedge clk_in);
    applyStimulus(0, 32'h0, 0, 0, 0, 1);
    rst_n_in = 1'b0;
    #1;
    checkVal("rst_count",      64'(count),         64'd0);
    checkVal("rst_empty",      64'(empty),         64'd1);
    checkVal("rst_full",       64'(full),          64'd0);
    checkVal("rst_grant",      64'(alloc_grant),   64'd0);
    checkVal("rst_alloc_tag",  64'(alloc_tag),     64'd0);
    checkVal("rst_push_valid", 64'(push_valid),    64'd0);
    checkVal("rst_push_tag",   64'(push_tag),      64'd0);
    checkVal("rst_push_addr",  64'(push_src_addr), 64'd0);
    checkVal("rst_err",        64'(err),           64'd0);
    modelReset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  task automatic grantN(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1, base + 32'(4 * i), 0, 0, 0, 1);
      checkOutput();
    end
  endtask

  task automatic commitSeq(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 32'h0, 1, (first + i) % 16, 0, 1);
      checkOutput();
    end
  endtask

  task automatic randomPhase(input int cycles);
    bit req, cv, pf, rdy;
    int ctag;
    for (int c = 0; c < cycles; c++) begin
      rdy  = ($urandom_range(99) < 90);
      req  = ($urandom_range(99) < 65);
      pf   = ($urandom_range(99) < 3);
      cv   = ($urandom_range(99) < 45);
      ctag = $urandom_range(15);
      if (mTags.size() != 0 && $urandom_range(99) < 95) ctag = mTags[0];
      if (mTags.size() == 0 && $urandom_range(99) < 90) cv = 0;
      applyStimulus(req, $urandom, cv, ctag, pf, rdy);
      checkOutput();
    end
  endtask

  initial begin
    rst_n_in = 1'b1;
    applyStimulus(0, 32'h0, 0, 0, 0, 1);
    applyReset();

    // First grant and its push one cycle later.
    applyStimulus(1, 32'h1000, 0, 0, 0, 1);
    checkVal("first_grant", 64'(alloc_grant), 64'd1);
    checkVal("first_tag",   64'(alloc_tag),   64'd0);
    checkOutput();
    checkVal("first_push_valid", 64'(push_valid),    64'd1);
    checkVal("first_push_tag",   64'(push_tag),      64'd0);
    checkVal("first_push_addr",  64'(push_src_addr), 64'h1000);
    checkVal("first_count",      64'(count),         64'd1);

    // Fill to capacity, then one refused request.
    grantN(15, 32'h2000);
    checkVal("fill_full",  64'(full),  64'd1);
    checkVal("fill_count", 64'(count), 64'd16);
    applyStimulus(1, 32'h3000, 0, 0, 0, 1);
    checkVal("full_no_grant", 64'(alloc_grant), 64'd0);
    checkOutput();
    checkVal("full_no_push", 64'(push_valid), 64'd0);

    // Commit at full: bubble, then wrapped tag 0 is granted.
    applyStimulus(1, 32'h3004, 1, 0, 0, 1);
    checkVal("bubble_grant", 64'(alloc_grant), 64'd0);
    checkOutput();
    checkVal("bubble_count", 64'(count), 64'd15);
    applyStimulus(1, 32'h3008, 0, 0, 0, 1);
    checkVal("wrap_grant", 64'(alloc_grant), 64'd1);
    checkVal("wrap_tag",   64'(alloc_tag),   64'd0);
    checkOutput();
    checkVal("wrap_count", 64'(count), 64'd16);

    // Flush, rebuild head=3/tail=11, mispredict with request and commit.
    applyStimulus(0, 32'h0, 0, 0, 1, 1);
    checkOutput();
    grantN(11, 32'h4000);
    commitSeq(0, 3);
    checkVal("pre_pf_count", 64'(count),     64'd8);
    checkVal("pre_pf_tail",  64'(alloc_tag), 64'd11);
    applyStimulus(1, 32'h5000, 1, 3, 1, 1);
    checkVal("pf_grant", 64'(alloc_grant), 64'd0);
    checkOutput();
    checkVal("pf_count",      64'(count),      64'd0);
    checkVal("pf_tail",       64'(alloc_tag),  64'd0);
    checkVal("pf_push_valid", 64'(push_valid), 64'd0);
    checkVal("pf_err",        64'(err),        64'd0);

    // Illegal commit sets err without moving head; legal ones still work.
    grantN(7, 32'h6000);
    commitSeq(0, 5);
    checkVal("pre_err_count", 64'(count), 64'd2);
    commitSeq(6, 1);
    checkVal("bad_commit_err",   64'(err),   64'd1);
    checkVal("bad_commit_count", 64'(count), 64'd2);
    commitSeq(5, 1);
    checkVal("good_commit_count", 64'(count), 64'd1);
    checkVal("good_commit_err",   64'(err),   64'd1);
    commitSeq(6, 1);
    checkVal("head6_count", 64'(count), 64'd0);

    // Pause with a push pending.
    applyReset();
    grantN(5, 32'h7000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h8000, 1, 0, 0, 0);
      checkVal("pause_grant", 64'(alloc_grant), 64'd0);
      checkOutput();
      checkVal("pause_push_valid", 64'(push_valid),    64'd1);
      checkVal("pause_push_tag",   64'(push_tag),      64'd4);
      checkVal("pause_push_addr",  64'(push_src_addr), 64'h7010);
      checkVal("pause_count",      64'(count),         64'd5);
    end

    // Randomized traffic with mid-operation resets.
    for (int p = 0; p < 3; p++) begin
      randomPhase(700);
      applyReset();
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rob_tag_alloc.md
Name: rob_tag_alloc

Overview:
- Issue-side controller for the reorder buffer.
- Hands out ROB tags in program order to the dispatch stage through a request/grant handshake, then drives the ROB push port one cycle later.
- Reclaims tags on in-order commit and resets all allocation state on branch mispredict.
- Sole owner of ROB occupancy: full/empty/count come from here, not from the ROB.

Parameters:
- TAG_W, 4, tag width in bits; matches ROB tag field.
- NUM_TAGS, 16, tags in circulation; must equal 2**TAG_W and ROB_SIZE.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global ready; low = pause
- alloc_req  in  1  dispatch wants a tag this cycle
- alloc_pc  in  32  source address of dispatching inst
- alloc_grant  out  1  combinational grant; tag consumed this edge
- alloc_tag  out  TAG_W  tag that a grant this cycle receives (= tail)
- push_valid  out  1  registered push strobe to ROB
- push_tag  out  TAG_W  registered tag to ROB
- push_src_addr  out  32  registered address to ROB
- commit_valid  in  1  ROB retired its head entry
- commit_tag  in  TAG_W  tag of retired entry
- predict_fail  in  1  mispredict flush
- count  out  TAG_W+1  tags outstanding, 0..NUM_TAGS
- full  out  1  count == NUM_TAGS
- empty  out  1  count == 0
- err  out  1  sticky protocol-error flag

Behaviour:
- State: head, tail (TAG_W, wrap naturally mod NUM_TAGS), count (TAG_W+1), err, push_* output regs.
- Reset (async, rst_n_in low): head=tail=0, count=0, push_valid=0, push_tag=0, push_src_addr=0, err=0. Consequently full=0, empty=1, alloc_grant=0.
- Reset mid-operation drops all outstanding tags; no pending push survives.
- alloc_grant = alloc_req & rdy_in & !full & !predict_fail.
  - Uses registered count only.
  - A commit in the same cycle does not unblock a full allocator (one-cycle bubble, by design).
- alloc_tag = tail at all times, including when full (value meaningless then).
- Grant edge:
  - tail <= tail+1.
  - Next cycle: push_valid=1, push_tag=old tail, push_src_addr=alloc_pc.
  - Latency: grant-to-push exactly 1 cycle.
- No grant (rdy_in high): push_valid <= 0.
- Commit, when commit_valid & rdy_in & !predict_fail:
  - Legal iff count != 0 and commit_tag == head. Legal commit: head <= head+1.
  - Illegal commit (empty, or tag != head): err <= 1; head and count unchanged.
- count update: +1 on grant, -1 on legal commit, unchanged when both or neither occur.
  - Simultaneous grant + commit at count=1 → count stays 1, head and tail both advance.
- predict_fail (rdy_in high) has highest priority:
  - head=tail=0, count=0, push_valid=0.
  - Grant suppressed; commit ignored.
  - err preserved.
- rdy_in low: all registers hold, including push_valid, matching the ROB pause; alloc_grant=0; commits ignored.
- err clears only on reset.
- Wrap: tail NUM_TAGS-1 → 0 and head NUM_TAGS-1 → 0 with no special casing.

Decomposition:
- Shared package/macros: TAG_W, NUM_TAGS (aliases of ROB_SIZE_W/ROB_SIZE), rob_tag_t typedef, NULL-tag constant.
- No sub-module needed. The occupancy counter with full/empty is the only separable piece; keep it inline.

Test Plan:
- Reset, then release with alloc_req=1, alloc_pc=0x1000 → grant at cycle 0, alloc_tag=0; next cycle push_valid=1, push_tag=0, push_src_addr=0x1000; count=1.
- 16 back-to-back requests, no commits → tags 0..15 granted, full=1, count=16; 17th request alloc_grant=0 and push_valid=0 next cycle.
- At full, commit_tag=0 with alloc_req=1 same cycle → no grant that cycle, count=15; next cycle grant with alloc_tag=0 (wrap), count=16.
- 8 outstanding (head=3, tail=11), assert predict_fail with alloc_req=1 and commit_valid=1 → no grant, head=tail=0, count=0, push_valid=0, err=0.
- count=2, head=5, commit_tag=6 → err=1, head=5, count=2; following commit_tag=5 → head=6, count=1, err stays 1.
- rdy_in low for 3 cycles while push_valid=1, push_tag=4 → outputs held for all 3 cycles, alloc_grant=0, count unchanged.
